// File: rtl/number_sprite_renderer.sv
// Renders one 20x20 digit sprite over a flat background.
// The digit is double-buffered so a new value only appears at frame start.
module number_sprite_renderer #(
  parameter int unsigned ORIGIN_X    = 300,
  parameter int unsigned ORIGIN_Y    = 20,
  parameter int unsigned SPR_W       = 20,
  parameter int unsigned SPR_H       = 20,
  parameter logic [7:0]  TRANSPARENT = 8'h00,
  parameter logic [7:0]  BG_COLOR    = 8'h25
) (
  input  logic       i_clk2,
  input  logic       i_rst,
  input  logic [9:0] i_x,
  input  logic [9:0] i_y,
  input  logic       i_active,
  input  logic       i_frame_start,
  input  logic [3:0] i_digit,
  input  logic       i_digit_valid,
  output logic       o_digit_ready,
  output logic [9:0] o_numberaddr,
  output logic [3:0] o_digit_sel,
  input  logic [7:0] i_numberdata,
  output logic [7:0] o_pixel,
  output logic       o_pixel_valid
);

  localparam logic [10:0] X_LO = 11'(ORIGIN_X);
  localparam logic [10:0] X_HI = 11'(ORIGIN_X + SPR_W);
  localparam logic [10:0] Y_LO = 11'(ORIGIN_Y);
  localparam logic [10:0] Y_HI = 11'(ORIGIN_Y + SPR_H);
  localparam logic [9:0]  W10  = 10'(SPR_W);

  logic [3:0] disp_digit;
  logic [3:0] pend_digit;

  logic       x_in;
  logic       y_in;
  logic       in_box;
  logic [9:0] dx;
  logic [9:0] dy;
  logic [9:0] addr_next;

  logic       s1_in_box;
  logic       s1_active;
  logic       s2_in_box;
  logic       s2_active;

  // o_digit_ready doubles as the "pending register empty" flag.
  always_ff @(posedge i_clk2 or posedge i_rst) begin
    if (i_rst) begin
      disp_digit    <= '0;
      pend_digit    <= '0;
      o_digit_ready <= 1'b1;
    end else if (i_frame_start && !o_digit_ready) begin
      disp_digit    <= pend_digit;
      o_digit_ready <= 1'b1;
    end else if (i_digit_valid && o_digit_ready) begin
      pend_digit    <= i_digit;
      o_digit_ready <= 1'b0;
    end
  end

  always_comb begin
    x_in      = ({1'b0, i_x} >= X_LO) && ({1'b0, i_x} < X_HI);
    y_in      = ({1'b0, i_y} >= Y_LO) && ({1'b0, i_y} < Y_HI);
    in_box    = i_active && x_in && y_in && (disp_digit <= 4'd9);
    dx        = i_x - X_LO[9:0];
    dy        = i_y - Y_LO[9:0];
    addr_next = '0;
    if (in_box) addr_next = dy * W10 + dx;
  end

  always_ff @(posedge i_clk2 or posedge i_rst) begin
    if (i_rst) begin
      o_numberaddr  <= '0;
      o_digit_sel   <= '0;
      s1_in_box     <= 1'b0;
      s1_active     <= 1'b0;
      s2_in_box     <= 1'b0;
      s2_active     <= 1'b0;
      o_pixel       <= '0;
      o_pixel_valid <= 1'b0;
    end else begin
      o_numberaddr  <= addr_next;
      o_digit_sel   <= disp_digit;
      s1_in_box     <= in_box;
      s1_active     <= i_active;
      // Stage 2 waits out the ROM's one-cycle read latency.
      s2_in_box     <= s1_in_box;
      s2_active     <= s1_active;
      o_pixel_valid <= s2_active;
      if (!s2_active)
        o_pixel <= '0;
      else if (s2_in_box && (i_numberdata != TRANSPARENT))
        o_pixel <= i_numberdata;
      else
        o_pixel <= BG_COLOR;
    end
  end

endmodule

// File: doc/number_sprite_renderer.md
NUMBER_SPRITE_RENDERER -- requirements
Module: number_sprite_renderer

Interface
REQ-001 Parameter ORIGIN_X, default 300, sprite left column in pixels.
REQ-002 Parameter ORIGIN_Y, default 20, sprite top row in pixels.
REQ-003 Parameter SPR_W, default 20, sprite width; SPR_H, default 20, sprite height.
REQ-004 Parameter TRANSPARENT, default 8'h00, ROM value treated as see-through.
REQ-005 Parameter BG_COLOR, default 8'h25, pixel emitted outside the sprite or on transparent texels.
REQ-006 i_clk2  in  1  pixel clock; all state SHALL change on its rising edge.
REQ-007 i_rst  in  1  asynchronous, active-high reset.
REQ-008 i_x  in  10  current pixel column from the VGA timing block.
REQ-009 i_y  in  10  current pixel row from the VGA timing block.
REQ-010 i_active  in  1  visible-area flag for i_x/i_y.
REQ-011 i_frame_start  in  1  one-cycle pulse at start of each frame.
REQ-012 i_digit  in  4  new digit to display (0-9).
REQ-013 i_digit_valid  in  1  i_digit offered this cycle.
REQ-014 o_digit_ready  out  1  block can accept a digit this cycle.
REQ-015 o_numberaddr  out  10  registered address to the digit ROMs.
REQ-016 o_digit_sel  out  4  registered ROM select (which digit ROM drives i_numberdata).
REQ-017 i_numberdata  in  8  ROM pixel, valid one cycle after o_numberaddr/o_digit_sel.
REQ-018 o_pixel  out  8  rendered pixel colour.
REQ-019 o_pixel_valid  out  1  o_pixel corresponds to a visible pixel.

Function
REQ-020 Digit handshake: transfer occurs when i_digit_valid and o_digit_ready are both 1 at a rising edge; the digit is stored in a one-entry pending register.
REQ-021 o_digit_ready SHALL be 1 exactly when the pending register is empty (registered, no combinational path from inputs).
REQ-022 On i_frame_start with pending full: displayed digit <= pending, pending cleared; o_digit_ready 1 from next cycle.
REQ-023 On i_frame_start with a transfer in the same cycle and pending empty: new digit goes to pending only; displayed digit unchanged until next i_frame_start.
REQ-024 Displayed digit SHALL never change except on i_frame_start (no mid-frame tearing).
REQ-025 Stage 1: in_box = i_active and ORIGIN_X <= i_x < ORIGIN_X+SPR_W and ORIGIN_Y <= i_y < ORIGIN_Y+SPR_H.
REQ-026 Stage 1: o_numberaddr <= (i_y-ORIGIN_Y)*SPR_W + (i_x-ORIGIN_X) when in_box, else 0; result 0..399, computed at 10 bits, no multiplier needed for SPR_W=20 (dy*16+dy*4).
REQ-027 Stage 1: o_digit_sel <= displayed digit.
REQ-028 Displayed digit 10-15 SHALL be treated as blank: in_box forced 0.
REQ-029 in_box and i_active SHALL be delayed to align with i_numberdata (stage 2).
REQ-030 Stage 3: o_pixel <= i_numberdata if delayed in_box and i_numberdata != TRANSPARENT, else BG_COLOR; o_pixel_valid <= delayed i_active.
REQ-031 Total latency i_x/i_y/i_active to o_pixel/o_pixel_valid SHALL be exactly 3 cycles; throughput one pixel per cycle, no stalls.
REQ-032 When o_pixel_valid is 0, o_pixel SHALL be 8'h00.

Reset
REQ-033 While i_rst is 1: o_numberaddr 0, o_digit_sel 0, o_pixel 8'h00, o_pixel_valid 0, displayed digit 0, pending empty, all pipeline flags 0.
REQ-034 o_digit_ready SHALL be 1 in the first cycle after i_rst deasserts.
REQ-035 Reset mid-frame SHALL flush the pipeline; no stale pixel valid after release.

Verification
REQ-036 Reset, then i_x=300,i_y=20,i_active=1 -> o_numberaddr=0 after 1 cycle, o_pixel=ROM[0] (or 8'h25 if 8'h00) after 3 cycles, o_pixel_valid=1.
REQ-037 i_x=319,i_y=39 -> o_numberaddr=399; i_x=320,i_y=39 -> o_numberaddr=0, o_pixel=8'h25 3 cycles later.
REQ-038 Offer digit 7 mid-frame -> accepted, o_digit_ready 0, o_digit_sel stays 0 until i_frame_start; o_digit_sel=7 from first pixel after pulse, o_digit_ready back to 1.
REQ-039 Offer digit 3 while pending holds 5 -> not accepted (ready 0); digit 5 shown after next frame_start, 3 accepted afterwards.
REQ-040 Digit 12 committed -> every in-box pixel renders 8'h25; i_active=0 -> o_pixel_valid=0, o_pixel=8'h00.
REQ-041 Assert i_rst during in-box pixel streaming -> outputs 0 immediately, o_pixel_valid 0 for 3 cycles after release.
